// File: rtl/writeback_regfile_if.sv
// Writeback bus between execute (master) and the writeback/register-file stage (slave).
// Carries the retiring result, both destinations, the next RIP and the architectural state view.
interface writeback_regfile_if;
    logic                 wbValidIn;
    logic [0:3]           destRegIn;
    logic                 destRegValidIn;
    logic [63:0]          destRegValueIn;
    logic [0:3]           destRegisterSpecialIn;
    logic                 destRegisterSpecialValidIn;
    logic [63:0]          destRegisterSpecialValueIn;
    logic [0:63]          nextRipIn;
    logic [15:0][63:0]    registerFileOut;
    logic [0:63]          ripOut;
    logic                 wbStallOut;
    logic                 wbDoneOut;
    logic [63:0]          retiredCountOut;

    modport master (
        output wbValidIn, destRegIn, destRegValidIn, destRegValueIn,
        output destRegisterSpecialIn, destRegisterSpecialValidIn, destRegisterSpecialValueIn,
        output nextRipIn,
        input  registerFileOut, ripOut, wbStallOut, wbDoneOut, retiredCountOut
    );

    modport slave (
        input  wbValidIn, destRegIn, destRegValidIn, destRegValueIn,
        input  destRegisterSpecialIn, destRegisterSpecialValidIn, destRegisterSpecialValueIn,
        input  nextRipIn,
        output registerFileOut, ripOut, wbStallOut, wbDoneOut, retiredCountOut
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: owns the 16 x 64-bit register file and RIP, retires one instruction per
// cycle, and serialises two-destination instructions (e.g. RDX:RAX) over the single write
// port with a one-cycle stall.
// Optional feature: define WB_FORWARD_EN to make registerFileOut write-through.
module writeback_regfile #(
    parameter logic [63:0] RESET_RIP = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_regfile_if.slave   wb_io
);

    typedef enum logic {
        StIdle,
        StWriteSpecial
    } state_e;

    state_e             state_q;
    logic [15:0][63:0]  rf_q;
    logic [0:63]        rip_q;
    logic [3:0]         spec_code_q;
    logic [63:0]        spec_val_q;
    logic               done_q;
    logic [63:0]        count_q;
    logic [15:0][63:0]  rf_view;

    // Retire FSM: primary write + RIP in IDLE, deferred second write in WRITE_SPECIAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rf_q        <= '0;
            rip_q       <= RESET_RIP;
            spec_code_q <= '0;
            spec_val_q  <= '0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wb_io.wbValidIn) begin
                        if (wb_io.destRegValidIn) begin
                            rf_q[wb_io.destRegIn] <= wb_io.destRegValueIn;
                        end
                        rip_q <= wb_io.nextRipIn;
                        if (wb_io.destRegisterSpecialValidIn) begin
                            // Retirement completes only once the second write has landed.
                            spec_code_q <= wb_io.destRegisterSpecialIn;
                            spec_val_q  <= wb_io.destRegisterSpecialValueIn;
                            state_q     <= StWriteSpecial;
                        end else begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 64'd1;
                        end
                    end
                end
                StWriteSpecial: begin
                    // Lands after the primary write, so it wins on a shared code.
                    rf_q[spec_code_q] <= spec_val_q;
                    done_q            <= 1'b1;
                    count_q           <= count_q + 64'd1;
                    state_q           <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Architectural register view, optionally bypassing the write in flight.
    always_comb begin
        rf_view = rf_q;
`ifdef WB_FORWARD_EN
        if (state_q == StIdle && wb_io.wbValidIn && wb_io.destRegValidIn) begin
            rf_view[wb_io.destRegIn] = wb_io.destRegValueIn;
        end else if (state_q == StWriteSpecial) begin
            rf_view[spec_code_q] = spec_val_q;
        end
`endif
    end

    assign wb_io.registerFileOut = rf_view;
    assign wb_io.ripOut          = rip_q;
    assign wb_io.wbStallOut      = (state_q == StWriteSpecial);
    assign wb_io.wbDoneOut       = done_q;
    assign wb_io.retiredCountOut = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a register-file/RIP model plus a scoreboard of
// expected {RIP, retired count} entries popped on each done pulse.
module tb_writeback_regfile;

    localparam logic [63:0] RST_RIP = 64'h0000_0000_0000_FFF0;

    typedef struct packed {
        logic [63:0] rip;
        logic [63:0] cnt;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_regfile_if wb ();

    writeback_regfile #(.RESET_RIP(RST_RIP)) dut (
        .clk   (clk),
        .reset (reset),
        .wb_io (wb)
    );

    int                checks   = 0;
    int                failures = 0;
    sb_t               sb_q[$];
    logic [15:0][63:0] exp_rf;
    logic [63:0]       issued;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic [15:0][63:0] exp);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s reg[%0d]", tag, i), wb.registerFileOut[i], exp[i]);
        end
    endtask

    task automatic expect_done(input string tag);
        sb_t e;
        chk({tag, " done"}, {63'd0, wb.wbDoneOut}, 64'd1);
        chk({tag, " sb depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, " rip"}, wb.ripOut, e.rip);
            chk({tag, " count"}, wb.retiredCountOut, e.cnt);
        end
    endtask

    // Called #1 after an edge; leaves the instruction's inputs driven on return.
    task automatic issue(input string tag, input logic [3:0] d, input logic dv,
                         input logic [63:0] dval, input logic [3:0] s, input logic sv,
                         input logic [63:0] sval, input logic [63:0] rip);
        logic [15:0][63:0] view;
        wb.wbValidIn                  = 1'b1;
        wb.destRegIn                  = d;
        wb.destRegValidIn             = dv;
        wb.destRegValueIn             = dval;
        wb.destRegisterSpecialIn      = s;
        wb.destRegisterSpecialValidIn = sv;
        wb.destRegisterSpecialValueIn = sval;
        wb.nextRipIn                  = rip;
        issued = issued + 64'd1;
        sb_q.push_back('{rip: rip, cnt: issued});
        #1;
        if (dv) begin
`ifdef WB_FORWARD_EN
            chk({tag, " same-cycle view"}, wb.registerFileOut[d], dval);
`else
            chk({tag, " same-cycle view"}, wb.registerFileOut[d], exp_rf[d]);
`endif
        end
        @(posedge clk);
        #1;
        if (dv) exp_rf[d] = dval;
        if (sv) begin
            chk({tag, " stall"}, {63'd0, wb.wbStallOut}, 64'd1);
            chk({tag, " no early done"}, {63'd0, wb.wbDoneOut}, 64'd0);
            chk({tag, " rip early"}, wb.ripOut, rip);
            view = exp_rf;
`ifdef WB_FORWARD_EN
            view[s] = sval;
`endif
            chk_rf({tag, " mid"}, view);
            @(posedge clk);
            #1;
            exp_rf[s] = sval;
        end
        chk({tag, " stall end"}, {63'd0, wb.wbStallOut}, 64'd0);
        expect_done(tag);
        chk_rf(tag, exp_rf);
    endtask

    task automatic idle(input string tag);
        wb.wbValidIn = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " idle done"}, {63'd0, wb.wbDoneOut}, 64'd0);
        chk({tag, " idle stall"}, {63'd0, wb.wbStallOut}, 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_rf(tag, '0);
        chk({tag, " rip"}, wb.ripOut, RST_RIP);
        chk({tag, " count"}, wb.retiredCountOut, 64'd0);
        chk({tag, " stall"}, {63'd0, wb.wbStallOut}, 64'd0);
        chk({tag, " done"}, {63'd0, wb.wbDoneOut}, 64'd0);
    endtask

    initial begin
        reset                         = 1'b1;
        wb.wbValidIn                  = 1'b0;
        wb.destRegIn                  = '0;
        wb.destRegValidIn             = 1'b0;
        wb.destRegValueIn             = '0;
        wb.destRegisterSpecialIn      = '0;
        wb.destRegisterSpecialValidIn = 1'b0;
        wb.destRegisterSpecialValueIn = '0;
        wb.nextRipIn                  = '0;
        exp_rf                        = '0;
        issued                        = '0;

        #1;
        chk_reset_state("power-on reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle("after reset");
        chk("idle rip held", wb.ripOut, RST_RIP);

        issue("single", 4'd3, 1'b1, 64'hDEAD_BEEF, 4'd0, 1'b0, 64'h0, 64'h1000);
        issue("two-dest", 4'd0, 1'b1, 64'h5, 4'd2, 1'b1, 64'h7, 64'h1004);
        issue("collision", 4'd1, 1'b1, 64'hA, 4'd1, 1'b1, 64'hB, 64'h1008);
        issue("special only", 4'd8, 1'b0, 64'hBAD, 4'd14, 1'b1, 64'h99, 64'h100C);
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("b2b%0d", i), 4'(4 + i), 1'b1, 64'h100 + 64'(i), 4'd0, 1'b0,
                  64'h0, 64'h1010 + 64'(4 * i));
        end
        idle("after b2b");
        chk("b2b count", wb.retiredCountOut, 64'd8);
        issue("forward", 4'd9, 1'b1, 64'h42, 4'd0, 1'b0, 64'h0, 64'h1020);
        issue("overwrite", 4'd3, 1'b1, 64'hCAFE_F00D, 4'd15, 1'b1, 64'h1234_5678, 64'h1024);

        // Reset while WRITE_SPECIAL is pending: the second write must never land.
        wb.wbValidIn                  = 1'b1;
        wb.destRegIn                  = 4'd12;
        wb.destRegValidIn             = 1'b1;
        wb.destRegValueIn             = 64'h11;
        wb.destRegisterSpecialIn      = 4'd13;
        wb.destRegisterSpecialValidIn = 1'b1;
        wb.destRegisterSpecialValueIn = 64'h22;
        wb.nextRipIn                  = 64'h2000;
        @(posedge clk);
        #1;
        chk("pre-reset stall", {63'd0, wb.wbStallOut}, 64'd1);
        #1;
        reset        = 1'b1;
        wb.wbValidIn = 1'b0;
        #1;
        chk_reset_state("mid-special reset");
        sb_q.delete();
        exp_rf = '0;
        issued = '0;
        @(posedge clk);
        #1;
        chk_reset_state("held reset");
        reset = 1'b0;
        issue("post-reset", 4'd5, 1'b1, 64'h77, 4'd0, 1'b0, 64'h0, 64'h3000);
        idle("final");
        chk("sb drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural state owner for the pipeline: accepts retiring results from execute, writes them into the 16 x 64-bit general register file, and advances RIP. It drives the register-file array and the writeback stall that the read stage consumes. Two-destination instructions (IMUL/MUL/DIV writing RDX:RAX) use the single write port over two cycles under a stall.

## Interface
- RESET_RIP, 64'h0, RIP value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wbValidIn  in  1  a retiring instruction is presented this cycle
- destRegIn  in  [0:3]  primary destination register code
- destRegValidIn  in  1  primary destination is written
- destRegValueIn  in  [63:0]  primary result
- destRegisterSpecialIn  in  [0:3]  second destination (e.g. RDX)
- destRegisterSpecialValidIn  in  1  second destination is written
- destRegisterSpecialValueIn  in  [63:0]  second result
- nextRipIn  in  [0:63]  RIP after this instruction
- registerFileOut  out  [63:0] x16  architectural registers, indexed by register code
- ripOut  out  [0:63]  architectural RIP
- wbStallOut  out  1  writeback busy; upstream holds its inputs
- wbDoneOut  out  1  one-cycle pulse per fully retired instruction
- retiredCountOut  out  [63:0]  instructions retired since reset

## Operation
- FSM states: IDLE, WRITE_SPECIAL.
- IDLE, wbValidIn=1:
  - if destRegValidIn, write destRegValueIn to reg[destRegIn]; always load ripOut <= nextRipIn.
  - if destRegisterSpecialValidIn: latch special code/value, go to WRITE_SPECIAL; no done pulse yet.
  - else: wbDoneOut=1 next cycle, retiredCountOut += 1, stay IDLE.
- IDLE, wbValidIn=0: no state change.
- WRITE_SPECIAL: write latched value to reg[latched code]; wbDoneOut=1 next cycle, retiredCountOut += 1; return to IDLE. wbValidIn ignored in this state.
- wbStallOut = (state == WRITE_SPECIAL), decoded from registered state.
- Same code in both destinations: special write lands last, so its value wins.
- Special valid with primary invalid: still two cycles (primary slot idle).
- retiredCountOut wraps modulo 2^64.
- Reset values: all 16 registers 0, ripOut = RESET_RIP, state IDLE, wbStallOut 0, wbDoneOut 0, retiredCountOut 0, latched special code/value 0.

## Timing
- Write latency: 1 cycle; value visible on registerFileOut the cycle after the accepting edge.
- Single-destination instruction: accepted and retired at one edge; back-to-back acceptance every cycle.
- Two-destination instruction: 2 cycles; wbStallOut high exactly 1 cycle; next instruction accepted at the edge that ends WRITE_SPECIAL + 1.
- wbDoneOut is registered, high for exactly one cycle per instruction.
- Reset asserted mid-WRITE_SPECIAL: the pending special write is discarded, state returns to IDLE immediately, wbStallOut drops asynchronously.
- Reset deassertion: first acceptance at the first rising edge with reset low.

## Configuration
- WB_FORWARD_EN defined: registerFileOut is write-through. In IDLE with wbValidIn && destRegValidIn, entry destRegIn shows destRegValueIn combinationally in the same cycle. In WRITE_SPECIAL, the latched special entry shows the latched value. Read stage then sees results with zero bubble.
- WB_FORWARD_EN undefined: registerFileOut is purely the registered array; writes visible one cycle later. All other behaviour identical.

## Test plan
- Reset: assert reset mid-run -> all registerFileOut = 0, ripOut = RESET_RIP, retiredCountOut = 0, wbStallOut = 0.
- Single write: wbValidIn=1, destRegIn=3, value 64'hDEAD_BEEF, nextRipIn=64'h1000 -> next cycle reg[3]=64'hDEAD_BEEF, ripOut=64'h1000, wbDoneOut pulse, retiredCountOut=1.
- Two-destination: dest RAX(0)=64'h5, special RDX(2)=64'h7 -> cycle 1 reg[0]=5, wbStallOut=1; cycle 2 reg[2]=7, wbStallOut=0, wbDoneOut pulse, count +1.
- Collision: dest=1 value 64'hA, special=1 value 64'hB -> reg[1] ends 64'hB after 2 cycles.
- Back-to-back: 4 consecutive single-dest instructions to regs 4..7 -> no stall, 4 done pulses, count = 4.
- Forwarding (WB_FORWARD_EN on/off): dest=9 value 64'h42 -> registerFileOut[9]=64'h42 same cycle with macro; old value until next cycle without.
